dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_arb_starve.sv | 32 +++
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: owner tags, FSM states,
// the registered command bundle and the default starvation limit.
package dmem_arb_pkg;

    localparam int STARVE_MAX_DEFAULT = 4;

    // Command container widths; the top truncates to its own parameters.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 64;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } dmem_cmd_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation counter: counts pipeline grants while debug waits and
// raises force_dbg once the count reaches STARVE_MAX.
// Ports: clk, reset, d_req, p_gnt, d_gnt in; force_dbg out.
module dmem_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_req,
    input  logic p_gnt,
    input  logic d_gnt,
    output logic force_dbg
);

    localparam int CW = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (d_gnt || !d_req) begin
            cnt <= '0;
        end else if (p_gnt && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign force_dbg = d_req && (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (pipeline / debug) arbiter in front of a single data memory.
// Ports: clk, reset; p_* pipeline port; d_* debug port; mem_* memory
// side; busy. Config macro DMEM_ARB_STARVE_EN enables anti-starvation.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p_req,
    input  logic                  p_we,
    input  logic [DM_ADDRESS-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [2:0]            p_funct3,
    output logic                  p_gnt,
    output logic                  p_rvalid,
    output logic [DATA_W-1:0]     p_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_Funct3,
    input  logic [DATA_W-1:0]     mem_rd,

    output logic                  busy
);

    logic        force_dbg;
    logic        accept;
    owner_e      acc_own;
    dmem_cmd_t   acc_cmd;

    logic        cmd_v;
    owner_e      cmd_own;
    dmem_cmd_t   cmd_q;

    logic        rsp_v;
    owner_e      rsp_own;
    logic [DATA_W-1:0] rsp_data;

    arb_state_e  state, state_nx;
    logic        cmd_rd;
    logic        mem_on;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .d_req    (d_req),
        .p_gnt    (p_gnt),
        .d_gnt    (d_gnt),
        .force_dbg(force_dbg)
    );
`else
    // Pure strict priority: debug is never forced ahead of the pipeline.
    assign force_dbg = 1'b0;
`endif

    // Grants are combinational; reset masks both.
    assign p_gnt  = !reset && p_req && !force_dbg;
    assign d_gnt  = !reset && d_req && !p_gnt;
    assign accept = p_gnt || d_gnt;

    always_comb begin
        acc_own = OWN_PIPE;
        acc_cmd = '0;
        if (d_gnt) begin
            acc_own        = OWN_DBG;
            acc_cmd.we     = d_we;
            acc_cmd.addr   = CMD_ADDR_W'(d_addr);
            acc_cmd.wdata  = CMD_DATA_W'(d_wdata);
            acc_cmd.funct3 = d_funct3;
        end else begin
            acc_cmd.we     = p_we;
            acc_cmd.addr   = CMD_ADDR_W'(p_addr);
            acc_cmd.wdata  = CMD_DATA_W'(p_wdata);
            acc_cmd.funct3 = p_funct3;
        end
    end

    // Command stage: one accepted request per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_v   <= 1'b0;
            cmd_own <= OWN_PIPE;
            cmd_q   <= '0;
        end else begin
            cmd_v <= accept;
            if (accept) begin
                cmd_own <= acc_own;
                cmd_q   <= acc_cmd;
            end
        end
    end

    assign cmd_rd = cmd_v && !cmd_q.we;

    // Response stage: memory read data captured at the end of N+1.
    // rsp_own/rsp_data persist so rdata holds between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_v    <= 1'b0;
            rsp_own  <= OWN_PIPE;
            rsp_data <= '0;
        end else begin
            rsp_v <= cmd_rd;
            if (cmd_rd) begin
                rsp_own  <= cmd_own;
                rsp_data <= mem_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = ST_IDLE;
        unique case (state)
            ST_IDLE:   state_nx = accept ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: begin
                if (accept)      state_nx = ST_ACTIVE;
                else if (cmd_rd) state_nx = ST_DRAIN;
                else             state_nx = ST_IDLE;
            end
            ST_DRAIN:  state_nx = accept ? ST_ACTIVE : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // All outputs are forced low while reset is held.
    assign mem_on       = !reset && cmd_v;
    assign mem_MemRead  = mem_on && !cmd_q.we;
    assign mem_MemWrite = mem_on && cmd_q.we;
    assign mem_a        = mem_on ? cmd_q.addr[DM_ADDRESS-1:0] : '0;
    assign mem_wd       = mem_on ? cmd_q.wdata[DATA_W-1:0] : '0;
    assign mem_Funct3   = mem_on ? cmd_q.funct3 : 3'b000;

    assign p_rvalid = !reset && rsp_v && (rsp_own == OWN_PIPE);
    assign d_rvalid = !reset && rsp_v && (rsp_own == OWN_DBG);
    assign p_rdata  = (!reset && rsp_own == OWN_PIPE) ? rsp_data : '0;
    assign d_rdata  = (!reset && rsp_own == OWN_DBG) ? rsp_data : '0;

    assign busy = !reset && (state != ST_IDLE);

    // Container bits above the configured widths are never driven out.
    logic unused_bits;
    assign unused_bits = ^{cmd_q.addr, cmd_q.wdata, 32'(STARVE_MAX)};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with directed cases
// for latency, ordering, writes, starvation, reset and streaming.
module tb_dmem_arbiter;

    localparam int SMAX = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic        clk = 0;
    logic        reset = 1;
    logic        p_req = 0, p_we = 0;
    logic [8:0]  p_addr = 0;
    logic [31:0] p_wdata = 0;
    logic [2:0]  p_funct3 = 0;
    logic        p_gnt, p_rvalid;
    logic [31:0] p_rdata;
    logic        d_req = 0, d_we = 0;
    logic [8:0]  d_addr = 0;
    logic [31:0] d_wdata = 0;
    logic [2:0]  d_funct3 = 0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_MemRead, mem_MemWrite;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_Funct3;
    logic [31:0] mem_rd;
    logic        busy;

    dmem_arbiter #(
        .DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_funct3(p_funct3),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_Funct3(mem_Funct3),
        .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment memory behind the arbiter.
    logic [31:0] tbmem [512];
    assign mem_rd = tbmem[mem_a];
    always @(posedge clk) if (mem_MemWrite) tbmem[mem_a] <= mem_wd;

    // Reference model state.
    typedef struct {
        bit v; bit we; logic [8:0] a; logic [31:0] wd; logic [2:0] f3;
    } rq_t;
    typedef struct { bit own; logic [31:0] data; int cyc; } exp_t;

    logic [31:0] mdl [512];
    rq_t  pq, dq;
    exp_t sbq[$];
    int   cyc = 0;
    int   scnt = 0;
    bit   ecmd_v = 0;
    rq_t  ecmd;
    bit   prev_rd = 0;
    bit   started = 0;
    bit   last_dg = 0;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic accept(rq_t r, bit own);
        if (!r.we) sbq.push_back('{own, mdl[r.a], cyc + 1});
        else       mdl[r.a] = r.wd;
        ecmd_v = 1;
        ecmd   = r;
    endtask

    task automatic step();
        bit eg_p, eg_d, frc;
        @(negedge clk);
        p_req = pq.v; p_we = pq.we; p_addr = pq.a;
        p_wdata = pq.wd; p_funct3 = pq.f3;
        d_req = dq.v; d_we = dq.we; d_addr = dq.a;
        d_wdata = dq.wd; d_funct3 = dq.f3;
        #1;
        frc  = SEN && dq.v && (scnt == SMAX);
        eg_p = !reset && pq.v && !(dq.v && frc);
        eg_d = !reset && dq.v && !eg_p;
        chk("p_gnt", p_gnt, eg_p);
        chk("d_gnt", d_gnt, eg_d);
        last_dg = d_gnt;
        if (reset) begin
            chk("rst_ctl", {p_rvalid, d_rvalid, mem_MemRead,
                            mem_MemWrite, busy}, 0);
            chk("rst_data", p_rdata | d_rdata | mem_wd, 0);
            chk("rst_addr", {mem_a, mem_Funct3}, 0);
        end
        @(posedge clk);
        cyc++;
        prev_rd = ecmd_v && !ecmd.we;
        ecmd_v  = 0;
        if (reset) begin
            prev_rd = 0;
            scnt = 0;
            sbq.delete();
        end else begin
            if (eg_d || !dq.v) scnt = 0;
            else if (eg_p)     scnt++;
            if (eg_p) begin accept(pq, 0); pq.v = 0; end
            else if (eg_d) begin accept(dq, 1); dq.v = 0; end
        end
    endtask

    function automatic rq_t mk(bit we, logic [8:0] a,
                               logic [31:0] wd, logic [2:0] f3);
        rq_t r;
        r.v = 1; r.we = we; r.a = a; r.wd = wd; r.f3 = f3;
        return r;
    endfunction

    function automatic rq_t rnd();
        logic [8:0] a;
        a = ($urandom_range(0, 9) == 0) ? 9'h1FF
                                        : 9'($urandom_range(0, 15));
        return mk(1'($urandom), a, $urandom, 3'($urandom));
    endfunction

    // Monitor: memory-side, busy and response scoreboard.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (started && !reset) begin
            chk("mem_MemRead", mem_MemRead, ecmd_v && !ecmd.we);
            chk("mem_MemWrite", mem_MemWrite, ecmd_v && ecmd.we);
            chk("mem_a", mem_a, ecmd_v ? ecmd.a : 9'h0);
            chk("mem_wd", mem_wd, ecmd_v ? ecmd.wd : 32'h0);
            chk("mem_Funct3", mem_Funct3, ecmd_v ? ecmd.f3 : 3'h0);
            chk("busy", busy, ecmd_v || prev_rd);
            if (p_rvalid || d_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("stray_rvalid", {p_rvalid, d_rvalid}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rvalid_pair", {p_rvalid, d_rvalid},
                        e.own ? 2'b01 : 2'b10);
                    chk("rdata", e.own ? d_rdata : p_rdata, e.data);
                    chk("other_rdata", e.own ? p_rdata : d_rdata, 0);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                chk("missing_rvalid", 0, 1);
            end
        end
    end

    initial begin
        int dg;
        pq = '{default: 0};
        dq = '{default: 0};
        ecmd = '{default: 0};
        for (int i = 0; i < 512; i++) begin
            tbmem[i] = $urandom;
            mdl[i]   = tbmem[i];
        end
        tbmem[16] = 32'hDEADBEEF;
        mdl[16]   = 32'hDEADBEEF;

        reset = 1;
        repeat (2) step();
        @(negedge clk);
        reset = 0;
        started = 1;
        step();

        // Single pipeline read.
        pq = mk(0, 9'h010, 32'h0, 3'b010);
        step();
        repeat (3) step();

        // Simultaneous single-shot requests.
        pq = mk(0, 9'h005, 32'h0, 3'b010);
        dq = mk(0, 9'h006, 32'h0, 3'b010);
        repeat (5) step();

        // Debug byte write.
        dq = mk(1, 9'h003, 32'h55, 3'b000);
        repeat (4) step();

        // Read then write to the same address.
        pq = mk(0, 9'h007, 32'h0, 3'b010);
        step();
        pq = mk(1, 9'h007, 32'h12345678, 3'b010);
        step();
        pq = mk(0, 9'h007, 32'h0, 3'b010);
        repeat (4) step();

        // Eight back-to-back pipeline reads.
        for (int i = 0; i < 8; i++) begin
            pq = mk(0, 9'(i + 8), 32'h0, 3'b010);
            step();
        end
        repeat (4) step();

        // Both ports held high: starvation behaviour.
        dg = 0;
        for (int i = 0; i < 15; i++) begin
            if (!pq.v) pq = mk(1'($urandom), 9'(i), $urandom, 3'b010);
            if (!dq.v) dq = mk(1'($urandom), 9'(i + 32), $urandom, 3'b010);
            step();
            if (last_dg) dg++;
        end
        chk("starve_dgnt_count", dg, SEN ? 3 : 0);
        pq.v = 0;
        dq.v = 0;
        repeat (4) step();

        // Reset while a read sits in the command stage.
        pq = mk(0, 9'h010, 32'h0, 3'b010);
        step();
        @(negedge clk);
        reset = 1;
        repeat (2) step();
        @(negedge clk);
        reset = 0;
        repeat (4) step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (!pq.v && $urandom_range(0, 2) != 0) pq = rnd();
            if (!dq.v && $urandom_range(0, 2) == 0) dq = rnd();
            step();
        end
        pq.v = 0;
        dq.v = 0;
        repeat (6) step();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
